// File: rtl/nsa_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// Holds no logic of its own and applies no backpressure.
package nsa_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder used as the shared nibble datapath; purely combinational.
// Zero latency; no flow control or backpressure.
module ripple_carry_adder
    import nsa_pkg::*;
(
    output logic [NIBBLE_W-1:0] S,
    output logic                Cout,
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin
);
    logic [NIBBLE_W:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder feeding one nibble per cycle through a shared 4-bit adder; done NIBBLES cycles after start.
// No backpressure: start is ignored while busy; define NSA_SUB_EN to add a subtract input.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state_q, state_d;
    logic               accept, step, last;
    logic [WIDTH-1:0]   a_q, b_q, work_q, work_nxt, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, cout_q, ovf_q;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic               c_nib;

`ifdef NSA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last = (idx_q == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_nib = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

    ripple_carry_adder u_rca (
        .S    (s_nib),
        .Cout (c_nib),
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_q)
    );

    // Work register with the current nibble merged in, so the final edge can publish it directly.
    always_comb begin
        work_nxt = work_q;
        work_nxt[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = s_nib;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            idx_q   <= '0;
        end else if (step) begin
            work_q  <= work_nxt;
            carry_q <= c_nib;
            idx_q   <= idx_q + IDX_W'(1);
            if (last) begin
                sum_q  <= work_nxt;
                cout_q <= c_nib;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder against a plain-arithmetic model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst, start, cin, sub;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] sum;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] held_sum;
    logic             held_cout, held_ovf;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef NSA_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    task automatic check_w(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference: the whole sum in one wide addition; returns {overflow, cout, sum}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                               input logic mcin, input logic msub);
        logic [WIDTH-1:0] beff;
        logic [WIDTH:0]   full;
        logic             ovf;
        beff = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, beff} + {{WIDTH{1'b0}}, (msub ? 1'b1 : mcin)};
        ovf  = (ma[WIDTH-1] == beff[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return {ovf, full};
    endfunction

    // Called at a falling edge while the DUT is in IDLE or DONE; returns at the DONE cycle.
    task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic ocin,
                          input logic osub, input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                          input bit noisy);
        a = oa; b = ob; cin = ocin; sub = osub; start = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            @(negedge clk);
            check_1("busy_in_run", busy, 1'b1);
            check_1("done_in_run", done, 1'b0);
            check_w("sum_held_in_run", sum, held_sum);
            check_1("cout_held_in_run", cout, held_cout);
            check_1("ovf_held_in_run", overflow, held_ovf);
            if (noisy) begin
                start = 1'b1;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                cin   = 1'($urandom);
                sub   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check_1("busy_at_done", busy, 1'b0);
        check_1("done_pulse", done, 1'b1);
        check_w("sum", sum, es);
        check_1("cout", cout, ec);
        check_1("overflow", overflow, eo);
        held_sum = es; held_cout = ec; held_ovf = eo;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check_1("busy_idle", busy, 1'b0);
        check_1("done_idle", done, 1'b0);
        check_w("sum_idle", sum, held_sum);
    endtask

    initial begin
        logic [WIDTH+1:0] m;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_1("reset_busy", busy, 1'b0);
        check_1("reset_done", done, 1'b0);
        check_w("reset_sum", sum, '0);
        check_1("reset_cout", cout, 1'b0);
        check_1("reset_ovf", overflow, 1'b0);
        rst = 1'b0;
        idle_cycle();

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        // Back-to-back from DONE, with start and operands churning during RUN.
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        idle_cycle();

`ifdef NSA_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        idle_cycle();
`endif

        // Reset during the third RUN cycle discards the operation.
        a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_1("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_1("midrst_busy", busy, 1'b0);
        check_1("midrst_done", done, 1'b0);
        check_w("midrst_sum", sum, '0);
        check_1("midrst_cout", cout, 1'b0);
        check_1("midrst_ovf", overflow, 1'b0);
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        for (int i = 0; i < NIB + 1; i++) idle_cycle();
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        for (int n = 0; n < 30; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
`ifdef NSA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, m[WIDTH-1:0], m[WIDTH], m[WIDTH+1], bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
